// File: rtl/sram_port_ctrl_pkg.sv
// Shared types for the single-port instruction/data SRAM controller:
// requester ids, in-flight read tags and grant encodings.
package sram_port_ctrl_pkg;

    localparam int RD_LATENCY_DEF = 1;
    localparam int STARVE_MAX_DEF = 4;
    localparam int AW_DEF         = 32;
    localparam int STARVE_W       = 4;

    typedef enum logic {
        SRC_IF  = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    typedef struct packed {
        logic valid;
        src_e src;
        logic is_wr;
    } tag_t;

    typedef enum logic [1:0] {
        GNT_NONE   = 2'd0,
        GNT_IF     = 2'd1,
        GNT_MEM_WR = 2'd2,
        GNT_MEM_RD = 2'd3
    } gnt_e;

    function automatic tag_t tag_from_grant(input gnt_e gnt);
        tag_t t;
        t.valid = (gnt != GNT_NONE);
        t.src   = (gnt == GNT_IF) ? SRC_IF : SRC_MEM;
        t.is_wr = (gnt == GNT_MEM_WR);
        return t;
    endfunction

endpackage

// File: rtl/sram_port_ctrl_tag_pipe.sv
// Fixed-depth tag shift register that tracks each SRAM access until its
// read data (or write completion) is due back at the requester.
module sram_tag_pipe
    import sram_port_ctrl_pkg::*;
#(
    parameter int DEPTH = RD_LATENCY_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  tag_t tag_i,
    output tag_t tag_o
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            tag_t stage_d;
            tag_t stage_q;

            if (gi == 0) begin : g_head
                assign stage_d = tag_i;
            end else begin : g_body
                assign stage_d = g_stage[gi-1].stage_q;
            end

            // No stall path: every stage advances unconditionally.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end
        end
    endgenerate

    assign tag_o = g_stage[DEPTH-1].stage_q;

endmodule

// File: rtl/sram_port_ctrl.sv
// Arbitrates IF reads and MEM reads/writes onto one SRAM port, one grant per
// cycle, and returns responses in grant order after a fixed latency.
module sram_port_ctrl
    import sram_port_ctrl_pkg::*;
#(
    parameter int RD_LATENCY = RD_LATENCY_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int AW         = AW_DEF
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                if_req_i,
    input  logic [AW-1:0]       if_addr_i,
    output logic                if_addr_ok_o,
    output logic                if_data_ok_o,
    output logic [31:0]         if_rdata_o,

    input  logic                mem_req_i,
    input  logic [3:0]          mem_we_i,
    input  logic [AW-1:0]       mem_addr_i,
    input  logic [31:0]         mem_wdata_i,
    output logic                mem_addr_ok_o,
    output logic                mem_data_ok_o,
    output logic [31:0]         mem_rdata_o,

    output logic                sram_en_o,
    output logic [3:0]          sram_we_o,
    output logic [AW-1:0]       sram_addr_o,
    output logic [31:0]         sram_wdata_o,
    input  logic [31:0]         sram_rdata_i,

    output logic [STARVE_W-1:0] starve_cnt_o
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;
    logic                force_if;
    gnt_e                gnt;
    tag_t                tag_in;
    tag_t                tag_out;

    assign force_if = if_req_i && (starve_q == STARVE_LIM);

    // Grants are suppressed while reset is held so the SRAM port and the
    // requester handshakes stay quiet even if requests are already raised.
    always_comb begin
        gnt = GNT_NONE;
        if (rst_ni) begin
            if (force_if) begin
                gnt = GNT_IF;
            end else if (mem_req_i && (|mem_we_i)) begin
                gnt = GNT_MEM_WR;
            end else if (mem_req_i) begin
                gnt = GNT_MEM_RD;
            end else if (if_req_i) begin
                gnt = GNT_IF;
            end
        end
    end

    always_comb begin
        if_addr_ok_o  = 1'b0;
        mem_addr_ok_o = 1'b0;
        sram_en_o     = 1'b0;
        sram_we_o     = 4'b0;
        sram_addr_o   = '0;
        sram_wdata_o  = '0;
        unique case (gnt)
            GNT_IF: begin
                if_addr_ok_o = 1'b1;
                sram_en_o    = 1'b1;
                sram_addr_o  = if_addr_i;
            end
            GNT_MEM_WR: begin
                mem_addr_ok_o = 1'b1;
                sram_en_o     = 1'b1;
                sram_we_o     = mem_we_i;
                sram_addr_o   = mem_addr_i;
                sram_wdata_o  = mem_wdata_i;
            end
            GNT_MEM_RD: begin
                mem_addr_ok_o = 1'b1;
                sram_en_o     = 1'b1;
                sram_addr_o   = mem_addr_i;
            end
            default: begin
            end
        endcase
    end

    // Counts only cycles where IF is actively waiting; saturates at the limit.
    always_comb begin
        starve_d = starve_q;
        if (!if_req_i || (gnt == GNT_IF)) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign starve_cnt_o = starve_q;
    assign tag_in       = tag_from_grant(gnt);

    sram_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tag_i  (tag_in),
        .tag_o  (tag_out)
    );

    always_comb begin
        if_data_ok_o  = 1'b0;
        if_rdata_o    = '0;
        mem_data_ok_o = 1'b0;
        mem_rdata_o   = '0;
        if (tag_out.valid) begin
            if (tag_out.src == SRC_IF) begin
                if_data_ok_o = 1'b1;
                if_rdata_o   = sram_rdata_i;
            end else begin
                mem_data_ok_o = 1'b1;
                mem_rdata_o   = tag_out.is_wr ? 32'h0 : sram_rdata_i;
            end
        end
    end

endmodule

// File: doc/sram_port_ctrl.md
Name: sram_port_ctrl

Overview:
- Downstream of the IF/MEM request classifier. Owns the single physical instruction/data SRAM port.
- Each cycle it grants one of three requests: MEM write, MEM read, or IF read.
- It drives the SRAM, tracks in-flight reads through a tag pipeline matched to SRAM latency, and returns read data to the requester with addr_ok/data_ok pulses.
- A starvation counter guarantees forward progress for IF fetches under back-to-back MEM traffic.

Parameters:
- RD_LATENCY, 1, SRAM read latency in cycles; legal values 1..3.
- STARVE_MAX, 4, consecutive IF-denied cycles before IF is force-granted once; legal values 1..15.
- AW, 32, address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  IF read request, held until if_addr_ok.
- if_addr  in  AW  IF fetch address.
- if_addr_ok  out  1  IF request accepted this cycle.
- if_data_ok  out  1  IF read data valid this cycle.
- if_rdata  out  32  IF read data.
- mem_req  in  1  MEM request, held until mem_addr_ok.
- mem_we  in  4  byte write enables; 0 means read.
- mem_addr  in  AW  MEM address.
- mem_wdata  in  32  MEM write data.
- mem_addr_ok  out  1  MEM request accepted this cycle.
- mem_data_ok  out  1  MEM read data valid, or write complete.
- mem_rdata  out  32  MEM read data.
- sram_en  out  1  SRAM enable.
- sram_we  out  4  SRAM byte write enables.
- sram_addr  out  AW  SRAM address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid RD_LATENCY cycles after an enabled read.

Behaviour:
- Reset (reset=0, async): all outputs 0, tag pipeline cleared, starvation counter 0. In-flight reads are discarded; no data_ok after reset release for pre-reset requests.
- Grant, combinational, one per cycle:
  - Normal priority: MEM write (mem_req && |mem_we) > MEM read > IF read.
  - Force mode: if starve_cnt == STARVE_MAX and if_req=1, IF is granted over MEM.
- Grant effects:
  - The granted source's addr_ok=1 in the same cycle.
  - sram_en=1, and sram_we/addr/wdata are driven from the winner in the same cycle.
  - For a read, sram_we=0 and sram_wdata=0.
  - No grant → sram_en=0, sram_we=0.
- Starvation counter (sequential):
  - Increments when if_req=1 and IF is not granted; saturates at STARVE_MAX.
  - Clears to 0 when IF is granted or if_req=0.
- Tag pipeline: RD_LATENCY stages of {valid, src, is_wr}.
  - Stage 0 loads the grant; stages shift every cycle, with no stall.
  - At the last stage with valid=1:
    - src=IF: if_data_ok=1, if_rdata=sram_rdata.
    - src=MEM read: mem_data_ok=1, mem_rdata=sram_rdata.
    - src=MEM write: mem_data_ok=1, mem_rdata=0.
- Latency: data_ok asserts exactly RD_LATENCY cycles after addr_ok for reads and writes alike.
- Ordering: responses return in grant order; at most one data_ok per cycle.
- rdata outputs are 0 whenever the matching data_ok=0.
- Full throughput: one grant per cycle; there is no full condition because the pipeline never stalls. Requesters must accept data_ok unconditionally.
- Simultaneous events: a new grant and a completing response in the same cycle are both legal.
- A request dropped before addr_ok is ignored; no state is kept.

Decomposition:
- Shared package holds:
  - src enum: SRC_IF=0, SRC_MEM=1.
  - Tag struct {valid, src, is_wr}.
  - RD_LATENCY and STARVE_MAX defaults.
- One sub-module, sram_tag_pipe: a parameterised depth-RD_LATENCY shift register of tags with async active-low clear.

Test Plan:
- Lone IF read, addr 0x1000, RD_LATENCY=1 → if_addr_ok at cycle 0; sram_en=1, sram_addr=0x1000; if_data_ok at cycle 1 with if_rdata equal to the model word.
- MEM write (we=4'b0011, addr 0x20, wdata 0xDEADBEEF) concurrent with if_req → MEM granted and IF denied; mem_data_ok 1 cycle later; a later read of 0x20 returns the low half 0xBEEF merged.
- MEM read plus IF read every cycle, STARVE_MAX=4 → IF is denied 4 cycles and granted on the 5th; the pattern repeats; counter verified at 0..4.
- RD_LATENCY=3, alternating IF/MEM grants back-to-back → data_ok returns in grant order, each exactly 3 cycles after its addr_ok, one per cycle, with no drops.
- Reset asserted with 2 reads in flight → outputs go to 0 immediately; after release, no data_ok appears for the old reads; the first new read completes normally.
- No requests for 10 cycles → sram_en=0, all ok signals 0, starve_cnt stays 0.
